// File: rtl/tx_frame_buffer.sv
// Transmit frame buffer: stores readout words in a circular RAM, commits whole frames
// and streams each one to the frame FSM after a VALID/TX_ACK handshake.
module tx_frame_buffer #(
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned LEN_DEPTH = 4,
  parameter int unsigned MAX_LEN   = 1024,
  parameter int unsigned IFG_CYC   = 12
) (
  input  logic                           CLK,
  input  logic                           RST_N,
  input  logic                           WR_EN,
  input  logic [15:0]                    WR_DATA,
  input  logic                           WR_EOF,
  input  logic                           TX_ACK,
  output logic                           VALID,
  output logic [15:0]                    DOUT,
  output logic [$clog2(LEN_DEPTH+1)-1:0] FRM_CNT,
  output logic                           DROP,
  output logic                           BUSY
);

  localparam int unsigned DEPTH  = 2 ** ADDR_W;
  localparam int unsigned USED_W = ADDR_W + 1;
  localparam int unsigned LEN_W  = $clog2(MAX_LEN + 1);
  localparam int unsigned CNT_W  = $clog2(LEN_DEPTH + 1);
  localparam int unsigned LP_W   = (LEN_DEPTH > 1) ? $clog2(LEN_DEPTH) : 1;
  localparam int unsigned GAP_W  = (IFG_CYC > 1) ? $clog2(IFG_CYC) : 1;

  typedef enum logic [2:0] {StIdle, StFetch, StPresent, StStream, StGap} rd_state_e;

  logic [15:0]       mem [DEPTH];
  logic [LEN_W-1:0]  lf_mem [LEN_DEPTH];
  logic [15:0]       ram_q;

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, start_ptr_q, start_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [USED_W-1:0] used_q, used_d;
  logic [LEN_W-1:0]  frm_len_q, frm_len_d, commit_len_q, commit_len_d;
  logic [LEN_W-1:0]  len_q, len_d, left_q, left_d;
  logic [LP_W-1:0]   lf_wp_q, lf_wp_d, lf_rp_q, lf_rp_d;
  logic [CNT_W-1:0]  frm_cnt_q, frm_cnt_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic [15:0]       dout_q, dout_d;
  logic              dropping_q, dropping_d, drop_q, drop_d, commit_q, commit_d;
  rd_state_e         state_q, state_d;

  logic ram_full, over_len, lf_full, wr_ok, bad, drop_eof;
  logic rd_en, pop, free, frame_done;

  // Write side: accept, start dropping, or close a dropped frame by rewinding to its start.
  always_comb begin
    ram_full = (used_q == USED_W'(DEPTH));
    over_len = (frm_len_q == LEN_W'(MAX_LEN));
    // A commit still in the pipeline already owns a length slot.
    lf_full  = (32'(frm_cnt_q) + 32'(commit_q)) >= LEN_DEPTH;
    wr_ok    = WR_EN && !dropping_q && !ram_full && !over_len && !(WR_EOF && lf_full);
    bad      = WR_EN && !dropping_q && !wr_ok;
    drop_eof = WR_EN && WR_EOF && (dropping_q || bad);

    wr_ptr_d     = wr_ptr_q;
    start_ptr_d  = start_ptr_q;
    frm_len_d    = frm_len_q;
    dropping_d   = dropping_q;
    drop_d       = 1'b0;
    commit_d     = 1'b0;
    commit_len_d = commit_len_q;
    if (wr_ok) begin
      wr_ptr_d  = wr_ptr_q + ADDR_W'(1);
      frm_len_d = frm_len_q + LEN_W'(1);
      if (WR_EOF) begin
        commit_d     = 1'b1;
        commit_len_d = frm_len_q + LEN_W'(1);
        start_ptr_d  = wr_ptr_q + ADDR_W'(1);
        frm_len_d    = '0;
      end
    end
    if (drop_eof) begin
      wr_ptr_d   = start_ptr_q;
      frm_len_d  = '0;
      dropping_d = 1'b0;
      drop_d     = 1'b1;
    end else if (bad) begin
      dropping_d = 1'b1;
    end

    used_d = used_q;
    if (wr_ok)    used_d = used_d + USED_W'(1);
    if (free)     used_d = used_d - USED_W'(1);
    if (drop_eof) used_d = used_d - USED_W'(frm_len_q);

    lf_wp_d   = commit_q ? ((lf_wp_q == LP_W'(LEN_DEPTH - 1)) ? '0 : lf_wp_q + LP_W'(1))
                         : lf_wp_q;
    lf_rp_d   = pop ? ((lf_rp_q == LP_W'(LEN_DEPTH - 1)) ? '0 : lf_rp_q + LP_W'(1)) : lf_rp_q;
    frm_cnt_d = frm_cnt_q + CNT_W'(commit_q) - CNT_W'(frame_done);
  end

  // Read FSM; ram_q always holds the word after the one on DOUT (prefetch).
  always_comb begin
    state_d    = state_q;
    rd_en      = 1'b0;
    rd_ptr_d   = rd_ptr_q;
    len_d      = len_q;
    left_d     = left_q;
    gap_d      = gap_q;
    dout_d     = dout_q;
    pop        = 1'b0;
    free       = 1'b0;
    frame_done = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (frm_cnt_q != '0) begin
          pop     = 1'b1;
          len_d   = lf_mem[lf_rp_q];
          rd_en   = 1'b1;
          state_d = StFetch;
        end
      end
      StFetch: begin
        dout_d  = ram_q;
        rd_en   = (len_q > LEN_W'(1));
        state_d = StPresent;
      end
      StPresent: begin
        if (TX_ACK) begin
          free = 1'b1;
          if (len_q == LEN_W'(1)) begin
            frame_done = 1'b1;
            gap_d      = GAP_W'(IFG_CYC - 1);
            state_d    = StGap;
          end else begin
            dout_d  = ram_q;
            left_d  = len_q - LEN_W'(1);
            rd_en   = (len_q > LEN_W'(2));
            state_d = StStream;
          end
        end
      end
      StStream: begin
        free = 1'b1;
        if (left_q == LEN_W'(1)) begin
          frame_done = 1'b1;
          gap_d      = GAP_W'(IFG_CYC - 1);
          state_d    = StGap;
        end else begin
          dout_d = ram_q;
          left_d = left_q - LEN_W'(1);
          rd_en  = (left_q > LEN_W'(2));
        end
      end
      StGap: begin
        if (gap_q == '0) state_d = StIdle;
        else             gap_d   = gap_q - GAP_W'(1);
      end
      default: state_d = StIdle;
    endcase
    if (rd_en) rd_ptr_d = rd_ptr_q + ADDR_W'(1);
  end

  always_ff @(posedge CLK) begin
    if (wr_ok)    mem[wr_ptr_q]    <= WR_DATA;
    if (rd_en)    ram_q            <= mem[rd_ptr_q];
    if (commit_q) lf_mem[lf_wp_q]  <= commit_len_q;
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      wr_ptr_q     <= '0;
      start_ptr_q  <= '0;
      rd_ptr_q     <= '0;
      used_q       <= '0;
      frm_len_q    <= '0;
      commit_len_q <= '0;
      len_q        <= '0;
      left_q       <= '0;
      lf_wp_q      <= '0;
      lf_rp_q      <= '0;
      frm_cnt_q    <= '0;
      gap_q        <= '0;
      dout_q       <= '0;
      dropping_q   <= 1'b0;
      drop_q       <= 1'b0;
      commit_q     <= 1'b0;
      state_q      <= StIdle;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      start_ptr_q  <= start_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      used_q       <= used_d;
      frm_len_q    <= frm_len_d;
      commit_len_q <= commit_len_d;
      len_q        <= len_d;
      left_q       <= left_d;
      lf_wp_q      <= lf_wp_d;
      lf_rp_q      <= lf_rp_d;
      frm_cnt_q    <= frm_cnt_d;
      gap_q        <= gap_d;
      dout_q       <= dout_d;
      dropping_q   <= dropping_d;
      drop_q       <= drop_d;
      commit_q     <= commit_d;
      state_q      <= state_d;
    end
  end

  assign VALID   = (state_q == StPresent) || (state_q == StStream);
  assign BUSY    = (state_q != StIdle);
  assign DOUT    = dout_q;
  assign FRM_CNT = frm_cnt_q;
  assign DROP    = drop_q;

endmodule

// File: tb/tb_tx_frame_buffer.sv
// Directed bench for tx_frame_buffer (16-word RAM so pointer wrap and RAM-full drops are reachable).
module tb_tx_frame_buffer;

  localparam int unsigned IFG = 12;

  logic        CLK = 1'b0;
  logic        RST_N, WR_EN, WR_EOF, TX_ACK;
  logic [15:0] WR_DATA;
  logic        VALID, DROP, BUSY;
  logic [15:0] DOUT;
  logic [2:0]  FRM_CNT;

  int checks   = 0;
  int failures = 0;
  logic [15:0] exp_q[$];

  tx_frame_buffer #(
    .ADDR_W   (4),
    .LEN_DEPTH(4),
    .MAX_LEN  (1024),
    .IFG_CYC  (IFG)
  ) dut (
    .CLK    (CLK),
    .RST_N  (RST_N),
    .WR_EN  (WR_EN),
    .WR_DATA(WR_DATA),
    .WR_EOF (WR_EOF),
    .TX_ACK (TX_ACK),
    .VALID  (VALID),
    .DOUT   (DOUT),
    .FRM_CNT(FRM_CNT),
    .DROP   (DROP),
    .BUSY   (BUSY)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v)
    else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic wr(input logic [15:0] d, input logic eof);
    WR_EN   = 1'b1;
    WR_DATA = d;
    WR_EOF  = eof;
    tick();
    WR_EN   = 1'b0;
    WR_EOF  = 1'b0;
  endtask

  task automatic ack();
    TX_ACK = 1'b1;
    tick();
    TX_ACK = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (VALID !== 1'b1 && n < 60) begin
      tick();
      n++;
    end
    chk({tag, "_valid"}, 32'(VALID), 32'd1);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (BUSY !== 1'b0 && n < 60) begin
      tick();
      n++;
    end
    chk({tag, "_idle"}, 32'(BUSY), 32'd0);
  endtask

  // Receives one n-word frame, comparing against the front of exp_q.
  task automatic rx_frame(input string tag, input int n);
    wait_valid(tag);
    chk({tag, "_w0"}, 32'(DOUT), 32'(exp_q.pop_front()));
    ack();
    for (int i = 1; i < n; i++) begin
      chk($sformatf("%s_v%0d", tag, i), 32'(VALID), 32'd1);
      chk($sformatf("%s_w%0d", tag, i), 32'(DOUT), 32'(exp_q.pop_front()));
      tick();
    end
    chk({tag, "_end"}, 32'(VALID), 32'd0);
  endtask

  initial begin
    int t;
    RST_N = 1'b0; WR_EN = 1'b0; WR_EOF = 1'b0; WR_DATA = '0; TX_ACK = 1'b0;
    tick();
    tick();
    chk("rst_valid", 32'(VALID), 32'd0);
    chk("rst_dout", 32'(DOUT), 32'd0);
    chk("rst_frm_cnt", 32'(FRM_CNT), 32'd0);
    chk("rst_drop", 32'(DROP), 32'd0);
    chk("rst_busy", 32'(BUSY), 32'd0);
    RST_N = 1'b1;
    tick();

    // 4-word frame: latency, hold in PRESENT, back-to-back stream
    wr(16'h1111, 1'b0); wr(16'h2222, 1'b0); wr(16'h3333, 1'b0); wr(16'h4444, 1'b1);
    chk("t1_lat0_valid", 32'(VALID), 32'd0);
    tick();
    chk("t1_lat1_cnt", 32'(FRM_CNT), 32'd1);
    chk("t1_lat1_valid", 32'(VALID), 32'd0);
    tick();
    chk("t1_lat2_valid", 32'(VALID), 32'd0);
    chk("t1_lat2_busy", 32'(BUSY), 32'd1);
    tick();
    chk("t1_lat3_valid", 32'(VALID), 32'd1);
    chk("t1_w0", 32'(DOUT), 32'h1111);
    tick();
    tick();
    chk("t1_hold_valid", 32'(VALID), 32'd1);
    chk("t1_hold_w0", 32'(DOUT), 32'h1111);
    ack();
    chk("t1_w1", 32'(DOUT), 32'h2222);
    TX_ACK = 1'b1;  // ignored outside PRESENT
    tick();
    TX_ACK = 1'b0;
    chk("t1_w2", 32'(DOUT), 32'h3333);
    tick();
    chk("t1_w3", 32'(DOUT), 32'h4444);
    chk("t1_w3_valid", 32'(VALID), 32'd1);
    chk("t1_w3_cnt", 32'(FRM_CNT), 32'd1);
    tick();
    chk("t1_end_valid", 32'(VALID), 32'd0);
    chk("t1_end_cnt", 32'(FRM_CNT), 32'd0);
    chk("t1_end_dout_hold", 32'(DOUT), 32'h4444);
    for (int i = 0; i < IFG; i++) tick();
    chk("t1_gap_done", 32'(BUSY), 32'd0);

    // TX_ACK while idle does nothing
    ack();
    chk("t2_idle_ack_busy", 32'(BUSY), 32'd0);
    chk("t2_idle_ack_valid", 32'(VALID), 32'd0);

    // 1-word frame
    wr(16'hABCD, 1'b1);
    exp_q.push_back(16'hABCD);
    rx_frame("t2", 1);
    chk("t2_cnt", 32'(FRM_CNT), 32'd0);
    wait_idle("t2");

    // Two frames back to back, IFG between them
    wr(16'hA001, 1'b0); wr(16'hA002, 1'b0); wr(16'hA003, 1'b1);
    wr(16'hB001, 1'b0); wr(16'hB002, 1'b1);
    exp_q.push_back(16'hA001); exp_q.push_back(16'hA002); exp_q.push_back(16'hA003);
    exp_q.push_back(16'hB001); exp_q.push_back(16'hB002);
    tick();
    chk("t3_cnt2", 32'(FRM_CNT), 32'd2);
    rx_frame("t3a", 3);
    chk("t3_cnt1", 32'(FRM_CNT), 32'd1);
    t = 0;
    while (VALID !== 1'b1 && t < 40) begin
      tick();
      t++;
    end
    chk("t3_ifg", 32'((t + 1) >= (IFG + 2) && t < 40), 32'd1);
    rx_frame("t3b", 2);
    wait_idle("t3");

    // Length FIFO full: 5th frame dropped
    wr(16'hC001, 1'b1); wr(16'hC002, 1'b1); wr(16'hC003, 1'b1); wr(16'hC004, 1'b1);
    wr(16'hC005, 1'b1);
    chk("t4_drop", 32'(DROP), 32'd1);
    tick();
    chk("t4_drop_pulse", 32'(DROP), 32'd0);
    chk("t4_cnt4", 32'(FRM_CNT), 32'd4);
    for (int i = 1; i <= 4; i++) exp_q.push_back(16'hC000 + 16'(i));
    for (int i = 1; i <= 4; i++) rx_frame($sformatf("t4f%0d", i), 1);
    wait_idle("t4");
    for (int i = 0; i < 8; i++) tick();
    chk("t4_drained_valid", 32'(VALID), 32'd0);
    chk("t4_drained_cnt", 32'(FRM_CNT), 32'd0);

    // 20-word frame overflows the 16-word RAM; next frame wraps the pointers
    for (int i = 0; i < 20; i++) wr(16'hD000 + 16'(i), (i == 19));
    chk("t5_drop", 32'(DROP), 32'd1);
    tick();
    chk("t5_drop_pulse", 32'(DROP), 32'd0);
    tick();
    tick();
    tick();
    chk("t5_cnt0", 32'(FRM_CNT), 32'd0);
    chk("t5_no_valid", 32'(VALID), 32'd0);
    for (int i = 0; i < 8; i++) begin
      wr(16'hE000 + 16'(i), (i == 7));
      exp_q.push_back(16'hE000 + 16'(i));
    end
    rx_frame("t5", 8);
    wait_idle("t5");

    // Reset in the middle of STREAM
    for (int i = 0; i < 6; i++) wr(16'hF000 + 16'(i), (i == 5));
    wait_valid("t6");
    chk("t6_w0", 32'(DOUT), 32'hF000);
    ack();
    tick();
    chk("t6_w2", 32'(DOUT), 32'hF002);
    RST_N = 1'b0;
    tick();
    chk("t6_rst_valid", 32'(VALID), 32'd0);
    chk("t6_rst_cnt", 32'(FRM_CNT), 32'd0);
    chk("t6_rst_busy", 32'(BUSY), 32'd0);
    chk("t6_rst_dout", 32'(DOUT), 32'd0);
    RST_N = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      wr(16'h7700 + 16'(i), (i == 2));
      exp_q.push_back(16'h7700 + 16'(i));
    end
    rx_frame("t6", 3);
    chk("t6_cnt0", 32'(FRM_CNT), 32'd0);
    wait_idle("t6");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
